// File: rtl/store_commit_buffer_pkg.sv
// Shared types, funct3 codes and helpers
// for the committed-store buffer.
package store_commit_buffer_pkg;

   localparam int SCB_DEPTH = 4;

   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   function automatic logic st_f3_ok(input logic [2:0] f3);
      return (f3 == F3_SB) || (f3 == F3_SH)
          || (f3 == F3_SW);
   endfunction

   function automatic logic ld_f3_ok(input logic [2:0] f3);
      return (f3 == F3_LB) || (f3 == F3_LH)
          || (f3 == F3_LW) || (f3 == F3_LBU)
          || (f3 == F3_LHU);
   endfunction

   // Access size in bytes; unknown codes map to 4.
   function automatic logic [2:0] f3_size(input logic [2:0] f3);
      logic [2:0] sz;
      case (f3)
         F3_SB, F3_LBU: sz = 3'd1;
         F3_SH, F3_LHU: sz = 3'd2;
         default:       sz = 3'd4;
      endcase
      return sz;
   endfunction

   function automatic logic [31:0] ld_extend(
      input logic [31:0] raw,
      input logic [2:0]  f3
   );
      logic [31:0] v;
      unique case (1'b1)
         (f3 == F3_LB):  v = {{24{raw[7]}}, raw[7:0]};
         (f3 == F3_LBU): v = {24'd0, raw[7:0]};
         (f3 == F3_LH):  v = {{16{raw[15]}}, raw[15:0]};
         (f3 == F3_LHU): v = {16'd0, raw[15:0]};
         default:        v = raw;
      endcase
      return v;
   endfunction

endpackage

// File: rtl/store_commit_buffer_fwd_match.sv
// Compares one buffered store against a load
// probe: overlap, full cover, gathered bytes.
module sb_fwd_match
   import store_commit_buffer_pkg::*;
(
   input  logic [31:0] st_addr_i,
   input  logic [31:0] st_data_i,
   input  logic [2:0]  st_f3_i,
   input  logic [31:0] ld_addr_i,
   input  logic [2:0]  ld_f3_i,
   output logic        overlap_o,
   output logic        cover_o,
   output logic [31:0] bytes_o
);

   logic [2:0]  st_sz;
   logic [2:0]  ld_sz;
   logic [31:0] off;

   assign st_sz = f3_size(st_f3_i);
   assign ld_sz = f3_size(ld_f3_i);

   // Per load byte: modular offset into the store.
   always_comb begin
      overlap_o = 1'b0;
      cover_o   = 1'b1;
      bytes_o   = '0;
      off       = '0;
      for (int k = 0; k < 4; k++) begin
         if (k < int'(ld_sz)) begin
            off = ld_addr_i + 32'(k) - st_addr_i;
            if (off < {29'd0, st_sz}) begin
               overlap_o = 1'b1;
               bytes_o[8*k +: 8] =
                  st_data_i[{off[1:0], 3'b000} +: 8];
            end else begin
               cover_o = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/store_commit_buffer.sv
// Committed-store FIFO draining to data memory
// with store-to-load forwarding.
module store_commit_buffer
   import store_commit_buffer_pkg::*;
#(
   parameter int DEPTH = SCB_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        commit_valid,
   input  logic [31:0] commit_addr,
   input  logic [31:0] commit_data,
   input  logic [2:0]  commit_funct3,
   output logic        commit_ready,
   input  logic        mem_stall,
   output logic        ROB_MemWrite,
   output logic [31:0] ROB_memadress,
   output logic [2:0]  ROB_funct3,
   output logic [31:0] out_value,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   input  logic [2:0]  ld_funct3,
   output logic        fwd_hit,
   output logic [31:0] fwd_data,
   output logic        ld_stall,
   output logic        sb_empty,
   output logic        funct3_err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PW-1:0] head_q, head_d;
   logic [PW-1:0] tail_q, tail_d;
   logic [CW-1:0] count_q, count_d;
   logic          err_q, err_d;

   logic [31:0] addr_q [DEPTH];
   logic [31:0] data_q [DEPTH];
   logic [2:0]  f3_q   [DEPTH];

   logic acc, f3_ok, push, pop;

   logic [DEPTH-1:0] ovl;
   logic [DEPTH-1:0] cov;
   logic [31:0]      byt [DEPTH];
   logic             any;
   logic [PW-1:0]    sel;
   logic [PW-1:0]    idx;
   logic             ld_ok;

   assign sb_empty     = (count_q == '0);
   assign commit_ready = reset
                      && (count_q != CW'(DEPTH));
   assign acc          = commit_valid && commit_ready;
   assign f3_ok        = st_f3_ok(commit_funct3);
   assign push         = acc && f3_ok;
   assign ROB_MemWrite = !sb_empty && !mem_stall;
   assign pop          = ROB_MemWrite;
   assign funct3_err   = err_q;

   assign ROB_memadress = sb_empty ? '0
                                   : addr_q[head_q];
   assign ROB_funct3    = sb_empty ? '0
                                   : f3_q[head_q];
   assign out_value     = sb_empty ? '0
                                   : data_q[head_q];

   // Pointer/count next state from push and pop.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      err_d   = acc && !f3_ok;
      if (push) tail_d = tail_q + PW'(1);
      if (pop)  head_d = head_q + PW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      if (pop && !push) count_d = count_q - CW'(1);
   end

   // Control state; reset drops pending stores.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Entry payload; validity comes from count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_q[tail_q] <= commit_addr;
         data_q[tail_q] <= commit_data;
         f3_q[tail_q]   <= commit_funct3;
      end
   end

   for (genvar e = 0; e < DEPTH; e++) begin : g_match
      sb_fwd_match u_match (
         .st_addr_i (addr_q[e]),
         .st_data_i (data_q[e]),
         .st_f3_i   (f3_q[e]),
         .ld_addr_i (ld_addr),
         .ld_f3_i   (ld_funct3),
         .overlap_o (ovl[e]),
         .cover_o   (cov[e]),
         .bytes_o   (byt[e])
      );
   end

   // Oldest to youngest; last overlap wins.
   always_comb begin
      any = 1'b0;
      sel = '0;
      idx = '0;
      for (int a = 0; a < DEPTH; a++) begin
         idx = head_q + PW'(a);
         if ((CW'(a) < count_q) && ovl[idx]) begin
            any = 1'b1;
            sel = idx;
         end
      end
   end

   assign ld_ok = ld_valid && ld_f3_ok(ld_funct3);

   // Hit on full cover, retry on partial.
   always_comb begin
      fwd_hit  = 1'b0;
      ld_stall = 1'b0;
      fwd_data = '0;
      if (ld_ok && any) begin
         if (cov[sel]) begin
            fwd_hit  = 1'b1;
            fwd_data = ld_extend(byt[sel], ld_funct3);
         end else begin
            ld_stall = 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_store_commit_buffer.sv
// Self-checking bench for store_commit_buffer
// against a queue-based reference model.
module tb_store_commit_buffer;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        commit_valid = 1'b0;
   logic [31:0] commit_addr = '0;
   logic [31:0] commit_data = '0;
   logic [2:0]  commit_funct3 = '0;
   logic        commit_ready;
   logic        mem_stall = 1'b0;
   logic        ROB_MemWrite;
   logic [31:0] ROB_memadress;
   logic [2:0]  ROB_funct3;
   logic [31:0] out_value;
   logic        ld_valid = 1'b0;
   logic [31:0] ld_addr = '0;
   logic [2:0]  ld_funct3 = '0;
   logic        fwd_hit;
   logic [31:0] fwd_data;
   logic        ld_stall;
   logic        sb_empty;
   logic        funct3_err;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  f;
   } st_t;

   st_t q[$];
   logic exp_err = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;

   store_commit_buffer #(.DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .commit_valid  (commit_valid),
      .commit_addr   (commit_addr),
      .commit_data   (commit_data),
      .commit_funct3 (commit_funct3),
      .commit_ready  (commit_ready),
      .mem_stall     (mem_stall),
      .ROB_MemWrite  (ROB_MemWrite),
      .ROB_memadress (ROB_memadress),
      .ROB_funct3    (ROB_funct3),
      .out_value     (out_value),
      .ld_valid      (ld_valid),
      .ld_addr       (ld_addr),
      .ld_funct3     (ld_funct3),
      .fwd_hit       (fwd_hit),
      .fwd_data      (fwd_data),
      .ld_stall      (ld_stall),
      .sb_empty      (sb_empty),
      .funct3_err    (funct3_err)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic int bytes_of(input logic [2:0] f);
      case (f[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         default: return 4;
      endcase
   endfunction

   function automatic logic covers(
      input st_t s, input logic [31:0] ad);
      return (ad - s.a) < 32'(bytes_of(s.f));
   endfunction

   // Youngest store touching any load byte decides.
   function automatic void m_fwd(
      output logic h, output logic s,
      output logic [31:0] v);
      int n, y, o;
      logic [31:0] ad, raw;
      logic full;
      h = 0; s = 0; v = 0; raw = 0;
      full = 1; y = -1;
      if (!ld_valid) return;
      if (!(ld_funct3 inside
         {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
         return;
      n = bytes_of(ld_funct3);
      for (int e = q.size() - 1; e >= 0; e--)
         for (int k = 0; k < n; k++)
            if (y < 0 && covers(q[e], ld_addr + 32'(k)))
               y = e;
      if (y < 0) return;
      for (int k = 0; k < n; k++) begin
         ad = ld_addr + 32'(k);
         if (covers(q[y], ad)) begin
            o = int'(ad - q[y].a);
            raw[8*k +: 8] = q[y].d[8*o +: 8];
         end else begin
            full = 0;
         end
      end
      if (!full) begin
         s = 1;
         return;
      end
      h = 1;
      case (ld_funct3)
         3'b000: v = {{24{raw[7]}}, raw[7:0]};
         3'b100: v = {24'd0, raw[7:0]};
         3'b001: v = {{16{raw[15]}}, raw[15:0]};
         3'b101: v = {16'd0, raw[15:0]};
         default: v = raw;
      endcase
   endfunction

   function automatic logic [104:0] expv();
      logic rdy, mw, emp, h, s;
      logic [31:0] a, d, fd;
      logic [2:0] f;
      emp = (q.size() == 0);
      rdy = reset && (q.size() != DEPTH);
      mw  = !emp && !mem_stall;
      a   = emp ? 32'd0 : q[0].a;
      d   = emp ? 32'd0 : q[0].d;
      f   = emp ? 3'd0 : q[0].f;
      m_fwd(h, s, fd);
      return {rdy, mw, a, f, d, emp,
              h, s, fd, exp_err};
   endfunction

   function automatic logic [104:0] obsv();
      return {commit_ready, ROB_MemWrite,
              ROB_memadress, ROB_funct3,
              out_value, sb_empty, fwd_hit,
              ld_stall, fwd_data, funct3_err};
   endfunction

   // Advance one clock and update the model.
   task automatic tick();
      logic ok, pp, ps, rdy;
      rdy = reset && (q.size() != DEPTH);
      ok  = commit_funct3 inside
            {3'b000, 3'b001, 3'b010};
      pp  = (q.size() != 0) && !mem_stall;
      ps  = commit_valid && rdy && ok;
      @(posedge clk);
      if (!reset) begin
         q.delete();
         exp_err = 0;
      end else begin
         if (pp) void'(q.pop_front());
         if (ps) q.push_back('{a: commit_addr,
            d: commit_data, f: commit_funct3});
         exp_err = commit_valid && rdy && !ok;
      end
      #1;
   endtask

   task automatic push1(
      input logic [31:0] a, input logic [31:0] d,
      input logic [2:0] f);
      commit_valid  = 1;
      commit_addr   = a;
      commit_data   = d;
      commit_funct3 = f;
      tick();
      commit_valid  = 0;
   endtask

   task automatic drain();
      mem_stall    = 0;
      commit_valid = 0;
      ld_valid     = 0;
      for (int i = 0; i < 20 && !sb_empty; i++)
         tick();
      #1;
   endtask

   task automatic test_reset();
      reset = 0;
      commit_valid = 1;
      commit_funct3 = 3'b010;
      ld_valid = 1;
      ld_funct3 = 3'b010;
      #12;
      n_cmp++;
      if ({commit_ready, ROB_MemWrite, fwd_hit,
           ld_stall, sb_empty} !== 5'b00001) begin
         n_bad++;
         $display("FAIL reset_flags: got %b want 00001",
            {commit_ready, ROB_MemWrite, fwd_hit,
             ld_stall, sb_empty});
      end
      n_cmp++;
      if ({ROB_memadress, out_value, fwd_data,
           ROB_funct3} !== '0) begin
         n_bad++;
         $display("FAIL reset_data: got %h/%h/%h want 0",
            ROB_memadress, out_value, fwd_data);
      end
      tick();
      commit_valid = 0;
      ld_valid = 0;
      reset = 1;
      #1;
      n_cmp++;
      if (commit_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_release: ready %b want 1",
            commit_ready);
      end
   endtask

   task automatic test_basic_sw();
      push1(32'h100, 32'hDEADBEEF, 3'b010);
      #1;
      n_cmp++;
      if ({ROB_MemWrite, ROB_memadress, ROB_funct3,
           out_value} !== {1'b1, 32'h100, 3'b010,
           32'hDEADBEEF}) begin
         n_bad++;
         $display("FAIL basic_write: got %b %h %b %h",
            ROB_MemWrite, ROB_memadress,
            ROB_funct3, out_value);
      end
      tick();
      n_cmp++;
      if ({sb_empty, ROB_MemWrite} !== 2'b10) begin
         n_bad++;
         $display("FAIL basic_empty: got %b want 10",
            {sb_empty, ROB_MemWrite});
      end
   endtask

   task automatic test_funct3_err();
      push1(32'h140, 32'h1, 3'b011);
      #1;
      n_cmp++;
      if ({funct3_err, sb_empty} !== 2'b11) begin
         n_bad++;
         $display("FAIL f3err_pulse: got %b want 11",
            {funct3_err, sb_empty});
      end
      tick();
      n_cmp++;
      if (funct3_err !== 1'b0) begin
         n_bad++;
         $display("FAIL f3err_clear: got %b want 0",
            funct3_err);
      end
   endtask

   task automatic test_full_stall();
      logic [31:0] dat [5];
      int got;
      logic acc;
      mem_stall = 1;
      for (int i = 0; i < 5; i++) begin
         dat[i] = $urandom;
         commit_valid  = 1;
         commit_addr   = 32'h400 + 32'(4 * i);
         commit_data   = dat[i];
         commit_funct3 = 3'b010;
         #1;
         n_cmp++;
         if (commit_ready !== (i < 4)) begin
            n_bad++;
            $display("FAIL fill_ready%0d: got %b want %b",
               i, commit_ready, i < 4);
         end
         if (i < 4) tick();
      end
      mem_stall = 0;
      got = 0;
      for (int c = 0; c < 12 && got < 5; c++) begin
         #1;
         if (c == 0) begin
            n_cmp++;
            if (commit_ready !== 1'b0) begin
               n_bad++;
               $display("FAIL full_pushpop: ready %b want 0",
                  commit_ready);
            end
         end
         if (c == 1) begin
            n_cmp++;
            if (commit_ready !== 1'b1) begin
               n_bad++;
               $display("FAIL after_pop: ready %b want 1",
                  commit_ready);
            end
         end
         if (ROB_MemWrite) begin
            n_cmp++;
            if ({ROB_memadress, out_value} !==
                {32'h400 + 32'(4 * got), dat[got]}) begin
               n_bad++;
               $display("FAIL order%0d: got %h %h want %h %h",
                  got, ROB_memadress, out_value,
                  32'h400 + 32'(4 * got), dat[got]);
            end
            got++;
         end
         acc = commit_valid && commit_ready;
         tick();
         if (acc) commit_valid = 0;
      end
      n_cmp++;
      if (got != 5 || sb_empty !== 1'b1) begin
         n_bad++;
         $display("FAIL drain_count: got %0d writes want 5",
            got);
      end
   endtask

   task automatic test_forward_sign();
      mem_stall = 1;
      push1(32'h200, 32'h80FF1234, 3'b010);
      ld_valid = 1;
      ld_addr = 32'h203;
      ld_funct3 = 3'b000;
      #1;
      n_cmp++;
      if ({fwd_hit, ld_stall, fwd_data} !==
          {2'b10, 32'hFFFFFF80}) begin
         n_bad++;
         $display("FAIL fwd_lb: got %b%b %h want 10 ffffff80",
            fwd_hit, ld_stall, fwd_data);
      end
      ld_funct3 = 3'b100;
      #1;
      n_cmp++;
      if ({fwd_hit, fwd_data} !== {1'b1, 32'h80}) begin
         n_bad++;
         $display("FAIL fwd_lbu: got %b %h want 1 00000080",
            fwd_hit, fwd_data);
      end
      ld_addr = 32'h202;
      ld_funct3 = 3'b001;
      #1;
      n_cmp++;
      if ({fwd_hit, fwd_data} !== {1'b1, 32'hFFFF80FF}) begin
         n_bad++;
         $display("FAIL fwd_lh: got %b %h want 1 ffff80ff",
            fwd_hit, fwd_data);
      end
      ld_valid = 0;
      #1;
      n_cmp++;
      if ({fwd_hit, ld_stall, fwd_data} !== '0) begin
         n_bad++;
         $display("FAIL fwd_idle: got %b%b %h want 0",
            fwd_hit, ld_stall, fwd_data);
      end
      drain();
   endtask

   task automatic test_partial();
      mem_stall = 1;
      push1(32'h300, 32'h123456AA, 3'b000);
      ld_valid = 1;
      ld_addr = 32'h300;
      ld_funct3 = 3'b010;
      #1;
      n_cmp++;
      if ({fwd_hit, ld_stall} !== 2'b01) begin
         n_bad++;
         $display("FAIL part_lw: got %b want 01",
            {fwd_hit, ld_stall});
      end
      push1(32'h300, 32'h11223344, 3'b010);
      push1(32'h301, 32'h00000055, 3'b000);
      ld_funct3 = 3'b001;
      #1;
      n_cmp++;
      if ({fwd_hit, ld_stall} !== 2'b01) begin
         n_bad++;
         $display("FAIL part_lh: got %b want 01",
            {fwd_hit, ld_stall});
      end
      ld_addr = 32'h301;
      ld_funct3 = 3'b000;
      #1;
      n_cmp++;
      if ({fwd_hit, fwd_data} !== {1'b1, 32'h55}) begin
         n_bad++;
         $display("FAIL young_lb: got %b %h want 1 55",
            fwd_hit, fwd_data);
      end
      ld_addr = 32'h302;
      ld_funct3 = 3'b100;
      #1;
      n_cmp++;
      if ({fwd_hit, fwd_data} !== {1'b1, 32'h22}) begin
         n_bad++;
         $display("FAIL older_lbu: got %b %h want 1 22",
            fwd_hit, fwd_data);
      end
      drain();
   endtask

   task automatic test_wrap();
      mem_stall = 1;
      push1(32'hFFFFFFFE, 32'hA1B2C3D4, 3'b010);
      ld_valid = 1;
      ld_addr = 32'h0;
      ld_funct3 = 3'b101;
      #1;
      n_cmp++;
      if ({fwd_hit, fwd_data} !== {1'b1, 32'hA1B2}) begin
         n_bad++;
         $display("FAIL wrap_lhu: got %b %h want 1 a1b2",
            fwd_hit, fwd_data);
      end
      ld_addr = 32'hFFFFFFFC;
      ld_funct3 = 3'b010;
      #1;
      n_cmp++;
      if ({fwd_hit, ld_stall} !== 2'b01) begin
         n_bad++;
         $display("FAIL wrap_lw: got %b want 01",
            {fwd_hit, ld_stall});
      end
      drain();
   endtask

   task automatic test_reset_drain();
      mem_stall = 1;
      for (int i = 0; i < 3; i++)
         push1(32'h500 + 32'(4 * i), $urandom, 3'b010);
      reset = 0;
      #1;
      q.delete();
      n_cmp++;
      if ({sb_empty, ROB_MemWrite, commit_ready}
          !== 3'b100) begin
         n_bad++;
         $display("FAIL rst_mid: got %b want 100",
            {sb_empty, ROB_MemWrite, commit_ready});
      end
      mem_stall = 0;
      tick();
      tick();
      reset = 1;
      #1;
      n_cmp++;
      if (commit_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_ready: got %b want 1",
            commit_ready);
      end
      for (int c = 0; c < 5; c++) begin
         n_cmp++;
         if (ROB_MemWrite !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_nowrite%0d: got %b want 0",
               c, ROB_MemWrite);
         end
         tick();
      end
   endtask

   task automatic test_random();
      logic [31:0] base;
      logic [104:0] e, o;
      for (int c = 0; c < 600; c++) begin
         base = (c % 128 < 64) ? 32'h1000
                               : 32'hFFFFFFF8;
         commit_valid = ($urandom % 2) == 0;
         commit_addr  = base + 32'($urandom_range(0, 15));
         commit_data  = $urandom;
         if ($urandom % 8 == 0)
            commit_funct3 = 3'($urandom_range(3, 7));
         else
            commit_funct3 = 3'($urandom_range(0, 2));
         mem_stall = ($urandom % 3) == 0;
         ld_valid  = ($urandom % 4) != 0;
         ld_addr   = base + 32'($urandom_range(0, 15));
         ld_funct3 = 3'($urandom_range(0, 7));
         #1;
         e = expv();
         o = obsv();
         n_cmp++;
         if (o !== e) begin
            n_bad++;
            $display("FAIL rand%0d: got %h want %h",
               c, o, e);
         end
         tick();
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_basic_sw();
      test_funct3_err();
      test_full_stall();
      test_forward_sign();
      test_partial();
      test_wrap();
      test_reset_drain();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
         n_cmp, n_bad);
      $finish;
   end

endmodule
